muldiv_sequencer: RTL



---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
// negate() works on a wide vector; callers cast the result down to their own width.
package muldiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Wide enough for a 2*WIDTH product with WIDTH up to 64.
   localparam int NEG_W = 128;

   function automatic logic [NEG_W-1:0] negate(input logic [NEG_W-1:0] x);
      return ~x + NEG_W'(1);
   endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle,
// with sign handling around an unsigned magnitude datapath.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t               state, state_nx;
   logic [CW-1:0]        cnt;
   logic [2:0]           f3_q;
   logic [WIDTH-1:0]     b_mag;
   logic [2*WIDTH-1:0]   acc;
   logic                 neg_res, neg_rem;
   logic                 done_q;
   logic [WIDTH-1:0]     result_q;

   logic                 a_neg, b_neg, div_zero, div_ovf, special, accept;
   logic [WIDTH-1:0]     a_mag_in, b_mag_in, special_res, fix_res;
   logic [2*WIDTH-1:0]   prod, acc_step;
   logic [WIDTH:0]       mul_sum, div_diff;

   // Handshake: start is taken only in IDLE with flush low; stall holds the pipeline from
   // the accept cycle until the cycle before done; done pulses once with result valid.
   assign accept = (state == IDLE) && start && !flush;

   always_comb begin
      a_neg    = op_a[WIDTH-1] &&
                 (funct3 inside {F3_MUL, F3_MULH, F3_MULHSU, F3_DIV, F3_REM});
      b_neg    = op_b[WIDTH-1] && (funct3 inside {F3_MUL, F3_MULH, F3_DIV, F3_REM});
      a_mag_in = a_neg ? WIDTH'(negate(NEG_W'(op_a))) : op_a;
      b_mag_in = b_neg ? WIDTH'(negate(NEG_W'(op_b))) : op_b;
      div_zero = funct3[2] && (op_b == '0);
      div_ovf  = (funct3 == F3_DIV || funct3 == F3_REM) &&
                 (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
      special  = div_zero || div_ovf;
      // REM variants have funct3[1] set.
      if (div_zero) special_res = funct3[1] ? op_a : '1;
      else          special_res = funct3[1] ? '0 : op_a;
   end

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
      div_diff = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, b_mag};
      if (!f3_q[2])        acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (!div_diff[WIDTH])
                           acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                 acc_step = {acc[2*WIDTH-2:0], 1'b0};
   end

   always_comb begin
      prod = neg_res ? (2*WIDTH)'(negate(NEG_W'(acc))) : acc;
      case (f3_q)
         F3_MUL:           fix_res = prod[WIDTH-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:
                           fix_res = prod[2*WIDTH-1:WIDTH];
         F3_DIV, F3_DIVU:  fix_res = neg_res ? WIDTH'(negate(NEG_W'(acc[WIDTH-1:0])))
                                             : acc[WIDTH-1:0];
         default:          fix_res = neg_rem ? WIDTH'(negate(NEG_W'(acc[2*WIDTH-1:WIDTH])))
                                             : acc[2*WIDTH-1:WIDTH];
      endcase
   end

   always_comb begin
      state_nx = state;
      if (flush) state_nx = IDLE;
      else begin
         case (state)
            IDLE: if (start) state_nx = special ? DONE : CALC;
            CALC: if (cnt == CW'(1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         f3_q     <= '0;
         b_mag    <= '0;
         acc      <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state  <= state_nx;
         done_q <= (state_nx == DONE);
         if (accept) begin
            f3_q    <= funct3;
            b_mag   <= b_mag_in;
            acc     <= {{WIDTH{1'b0}}, a_mag_in};
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= CW'(WIDTH);
            if (special) result_q <= special_res;
         end else if (state == CALC && !flush) begin
            cnt <= cnt - CW'(1);
            acc <= acc_step;
         end else if (state == FIX && !flush) begin
            result_q <= fix_res;
         end
      end
   end

   assign busy   = (state != IDLE);
   assign stall  = accept || (state == CALC) || (state == FIX);
   assign done   = done_q;
   assign result = result_q;

endmodule
